// File: rtl/axis_multichannel_dump.sv
// axis_multichannel_dump
//   Per-channel result memory. The accumulator writes one word per channel
//   index through the write port. On dump_start, all CHANNELS words are read
//   in index order and sent as one AXI-Stream frame, with tlast on the last
//   channel. When CLEAR_ON_READ is set, each word is zeroed as it is read.
// Ports:
//   aclk, areset            clock; synchronous active-high reset
//   wr_en/wr_addr/wr_data   external write port (accepted only while idle)
//   dump_start              single-cycle dump request
//   busy                    dump in progress
//   wr_dropped              sticky flag: a write was discarded while busy
//   m_axis_*                AXI-Stream master, one beat per channel
module axis_multichannel_dump #(
   parameter int DATA_WIDTH    = 16,
   parameter int CHANNELS      = 1024,
   parameter bit CLEAR_ON_READ = 1'b1
) (
   input  logic                        aclk,
   input  logic                        areset,
   input  logic                        wr_en,
   input  logic [$clog2(CHANNELS)-1:0] wr_addr,
   input  logic [DATA_WIDTH-1:0]       wr_data,
   input  logic                        dump_start,
   output logic                        busy,
   output logic                        wr_dropped,
   output logic [DATA_WIDTH-1:0]       m_axis_tdata,
   output logic                        m_axis_tvalid,
   output logic                        m_axis_tlast,
   input  logic                        m_axis_tready
);
   localparam int AW = $clog2(CHANNELS);
   localparam logic [AW-1:0] LAST_ADDR = AW'(CHANNELS - 1);

   typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;
   state_t state;

   logic [DATA_WIDTH-1:0] mem [CHANNELS];
   logic [AW-1:0]         rd_addr;
   logic                  rd_vld;    // a read issued last cycle, data in rd_data
   logic                  rd_last;
   logic [DATA_WIDTH-1:0] rd_data;

   // Second FIFO entry; the first entry is the m_axis_* register set itself.
   logic                  sk_vld;
   logic                  sk_last;
   logic [DATA_WIDTH-1:0] sk_data;

   logic                  pop;
   logic                  issue;
   logic [1:0]            occ;
   logic                  mem_we;
   logic [AW-1:0]         mem_wa;
   logic [DATA_WIDTH-1:0] mem_wd;

   assign busy = (state != IDLE);
   assign pop  = m_axis_tvalid & m_axis_tready;

   // Credit: buffered words plus the read in flight must leave room. A beat
   // leaving this cycle frees a slot, which keeps one read per cycle when the
   // sink never stalls.
   assign occ   = {1'b0, m_axis_tvalid} + {1'b0, sk_vld} + {1'b0, rd_vld};
   assign issue = (state == READ) && (occ < (2'd2 + {1'b0, pop}));

   // Single write port: external writes while idle, clear-on-read otherwise.
   always_comb begin
      mem_we = 1'b0;
      mem_wa = wr_addr;
      mem_wd = wr_data;
      if (state == IDLE) begin
         mem_we = wr_en;
      end else if (issue && CLEAR_ON_READ) begin
         mem_we = 1'b1;
         mem_wa = rd_addr;
         mem_wd = '0;
      end
      if (areset) mem_we = 1'b0;
   end

   // Read-before-write: a cleared word still returns its old value.
   always_ff @(posedge aclk) begin
      if (mem_we) mem[mem_wa] <= mem_wd;
      if (issue)  rd_data     <= mem[rd_addr];
   end

   always_ff @(posedge aclk) begin
      if (areset) begin
         state         <= IDLE;
         rd_addr       <= '0;
         rd_vld        <= 1'b0;
         rd_last       <= 1'b0;
         wr_dropped    <= 1'b0;
         sk_vld        <= 1'b0;
         sk_last       <= 1'b0;
         sk_data       <= '0;
         m_axis_tvalid <= 1'b0;
         m_axis_tlast  <= 1'b0;
         m_axis_tdata  <= '0;
      end else begin
         rd_vld <= issue;
         if (issue) begin
            rd_last <= (rd_addr == LAST_ADDR);
            rd_addr <= rd_addr + AW'(1);
         end

         case (state)
            IDLE: if (dump_start) begin
               state      <= READ;
               rd_addr    <= '0;
               wr_dropped <= 1'b0;
            end
            READ: begin
               if (wr_en) wr_dropped <= 1'b1;
               if (issue && rd_addr == LAST_ADDR) state <= DRAIN;
            end
            DRAIN: begin
               if (wr_en) wr_dropped <= 1'b1;
               if (pop && m_axis_tlast) state <= IDLE;
            end
            default: state <= IDLE;
         endcase

         // Head only changes when empty or handshaking, so tdata/tlast hold
         // steady under backpressure.
         if (!m_axis_tvalid || pop) begin
            if (sk_vld) begin
               m_axis_tvalid <= 1'b1;
               m_axis_tdata  <= sk_data;
               m_axis_tlast  <= sk_last;
               sk_vld        <= rd_vld;
               sk_data       <= rd_data;
               sk_last       <= rd_last;
            end else begin
               m_axis_tvalid <= rd_vld;
               m_axis_tlast  <= rd_vld & rd_last;
               if (rd_vld) m_axis_tdata <= rd_data;
            end
         end else if (rd_vld) begin
            sk_vld  <= 1'b1;
            sk_data <= rd_data;
            sk_last <= rd_last;
         end
      end
   end
endmodule

// File: tb/tb_axis_multichannel_dump.sv
// Directed bench for axis_multichannel_dump: DUT A (20 channels, clear on
// read) and DUT B (5 channels, no clear). Inputs change and outputs are
// sampled on the falling edge.
module tb_axis_multichannel_dump;
   localparam int DW  = 16;
   localparam int CHA = 20;
   localparam int CHB = 5;
   localparam int AWA = 5;
   localparam int AWB = 3;

   logic aclk = 1'b0;
   logic areset = 1'b1;
   always #5 aclk = ~aclk;

   logic           a_wr_en = 1'b0, b_wr_en = 1'b0;
   logic           a_start = 1'b0, b_start = 1'b0;
   logic           tready = 1'b0;
   logic [AWA-1:0] wr_addr = '0;
   logic [DW-1:0]  wr_data = '0;

   logic          a_busy, a_drop, a_tvalid, a_tlast;
   logic          b_busy, b_drop, b_tvalid, b_tlast;
   logic [DW-1:0] a_tdata, b_tdata;

   int tests = 0;
   int fails = 0;
   logic [DW-1:0] expq [$];

   axis_multichannel_dump #(.DATA_WIDTH(DW), .CHANNELS(CHA), .CLEAR_ON_READ(1'b1)) u_a (
      .aclk(aclk), .areset(areset), .wr_en(a_wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .dump_start(a_start), .busy(a_busy), .wr_dropped(a_drop),
      .m_axis_tdata(a_tdata), .m_axis_tvalid(a_tvalid), .m_axis_tlast(a_tlast),
      .m_axis_tready(tready));

   axis_multichannel_dump #(.DATA_WIDTH(DW), .CHANNELS(CHB), .CLEAR_ON_READ(1'b0)) u_b (
      .aclk(aclk), .areset(areset), .wr_en(b_wr_en), .wr_addr(wr_addr[AWB-1:0]), .wr_data(wr_data),
      .dump_start(b_start), .busy(b_busy), .wr_dropped(b_drop),
      .m_axis_tdata(b_tdata), .m_axis_tvalid(b_tvalid), .m_axis_tlast(b_tlast),
      .m_axis_tready(tready));

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic fill(input bit sel, input int n);
      for (int i = 0; i < n; i++) begin
         if (sel) b_wr_en = 1'b1; else a_wr_en = 1'b1;
         wr_addr = AWA'(i);
         wr_data = DW'(i + 100);
         @(negedge aclk);
      end
      a_wr_en = 1'b0;
      b_wr_en = 1'b0;
   endtask

   task automatic exp_ramp(input int n);
      expq.delete();
      for (int i = 0; i < n; i++) expq.push_back(DW'(i + 100));
   endtask

   // Pulses dump_start now, then collects one frame against expq.
   task automatic dump(input bit sel, input int nch, input bit rnd,
                       input bit same_wr, input bit drop_wr, input bit rep);
      int cyc, nb, fv;
      logic tv, tl, bz, pl;
      logic [DW-1:0] td, pd;
      bit pend, done;
      if (sel) b_start = 1'b1; else a_start = 1'b1;
      if (same_wr) begin a_wr_en = 1'b1; wr_addr = 5; wr_data = 16'hBEEF; end
      cyc = 0; nb = 0; fv = -1; pend = 0; done = 0; pd = '0; pl = 1'b0;
      while (!done && cyc < 20 * nch + 20) begin
         @(negedge aclk);
         a_wr_en = 1'b0; a_start = 1'b0; b_start = 1'b0;
         if (rep && (cyc % 2 == 1) && cyc < nch) a_start = 1'b1;
         if (drop_wr && cyc == 3) begin a_wr_en = 1'b1; wr_addr = 3; wr_data = 16'h1234; end
         tv = sel ? b_tvalid : a_tvalid;
         tl = sel ? b_tlast  : a_tlast;
         td = sel ? b_tdata  : a_tdata;
         bz = sel ? b_busy   : a_busy;
         if (cyc == 0) check("busy_rise", bz, 1);
         if (pend) begin
            check("hold_valid", tv, 1);
            check("hold_data", td, pd);
            check("hold_last", tl, pl);
         end
         if (fv < 0 && tv) fv = cyc;
         tready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
         if (tv && tready) begin
            if (nb < nch) begin
               check($sformatf("beat%0d_data", nb), td, expq[nb]);
               check($sformatf("beat%0d_last", nb), tl, (nb == nch - 1));
            end else begin
               check("frame_overrun", nb, nch - 1);
            end
            nb++;
            pend = 0;
            if (tl) done = 1;
         end else begin
            pend = tv; pd = td; pl = tl;
         end
         cyc++;
      end
      check("frame_done", done, 1);
      check("beat_count", nb, nch);
      if (!rnd) check("first_valid_cycle", fv, 2);
      @(negedge aclk);
      check("busy_fall", sel ? b_busy : a_busy, 0);
      check("valid_fall", sel ? b_tvalid : a_tvalid, 0);
   endtask

   initial begin
      bit sawlast;
      areset = 1'b1;
      repeat (2) @(negedge aclk);
      check("rst_busy", a_busy, 0);
      check("rst_drop", a_drop, 0);
      check("rst_tvalid", a_tvalid, 0);
      check("rst_tlast", a_tlast, 0);
      check("rst_tdata", a_tdata, 0);
      check("rst_b_tvalid", b_tvalid, 0);
      areset = 1'b0;
      @(negedge aclk);

      // Ramp fill, write to channel 5 alongside dump_start, dropped write mid-dump.
      fill(0, CHA);
      exp_ramp(CHA);
      expq[5] = 16'hBEEF;
      dump(0, CHA, 0, 1, 1, 0);
      check("drop_flag_set", a_drop, 1);

      // Second dump with no writes: all cleared, and the dropped write never landed.
      expq.delete();
      for (int i = 0; i < CHA; i++) expq.push_back('0);
      dump(0, CHA, 0, 0, 0, 0);
      check("drop_flag_cleared", a_drop, 0);

      // Random backpressure.
      fill(0, CHA);
      exp_ramp(CHA);
      dump(0, CHA, 1, 0, 0, 0);

      // Repeated dump_start during a dump yields exactly one frame.
      fill(0, CHA);
      exp_ramp(CHA);
      dump(0, CHA, 0, 0, 0, 1);
      for (int c = 0; c < 6; c++) begin
         check("rep_idle_valid", a_tvalid, 0);
         check("rep_idle_busy", a_busy, 0);
         @(negedge aclk);
      end

      // Reset sampled 12 edges after dump_start: channels 0..10 already read.
      fill(0, CHA);
      a_start = 1'b1;
      sawlast = 0;
      for (int c = 0; c < 12; c++) begin
         @(negedge aclk);
         a_start = 1'b0;
         tready = 1'b1;
         if (a_tvalid && a_tlast) sawlast = 1;
      end
      areset = 1'b1;
      @(negedge aclk);
      check("abort_no_tlast_seen", sawlast, 0);
      check("abort_tvalid", a_tvalid, 0);
      check("abort_busy", a_busy, 0);
      check("abort_tlast", a_tlast, 0);
      areset = 1'b0;
      @(negedge aclk);
      exp_ramp(CHA);
      for (int i = 0; i <= 10; i++) expq[i] = '0;
      dump(0, CHA, 0, 0, 0, 0);

      // No clear-on-read: second frame repeats the first.
      fill(1, CHB);
      exp_ramp(CHB);
      dump(1, CHB, 0, 0, 0, 0);
      dump(1, CHB, 0, 0, 0, 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
